// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction sequencer: byte width, FSM states
// and chip-select levels.
package spi_pkg;

    localparam int BYTE = 8;

    localparam logic CS_ACTIVE = 1'b0;
    localparam logic CS_IDLE   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FETCH,
        ST_EXCH,
        ST_WAIT,
        ST_RXOUT,
        ST_GAP,
        ST_HOLD
    } state_t;

    // States whose duration is governed by the shared delay counter.
    function automatic logic is_timed(input state_t s);
        return (s == ST_SETUP) || (s == ST_GAP) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/spi_delay_cnt.sv
// Loadable down-counter that times the SETUP, GAP and HOLD states.
// Holds at zero; a load always wins over a decrement.
module spi_delay_cnt #(
    parameter int DLY_W = 8
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             iload,
    input  logic [DLY_W-1:0] iload_val,
    input  logic             idec,
    output logic [DLY_W-1:0] ovalue,
    output logic             ozero
);

    logic [DLY_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            cnt <= '0;
        end else if (iload) begin
            cnt <= iload_val;
        end else if (idec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign ovalue = cnt;
    assign ozero  = (cnt == '0);

endmodule

// File: rtl/spi_xfer_seq.sv
// Multi-byte SPI burst sequencer: frames a command with chip select, feeds TX
// bytes to the byte-exchange stage one at a time and returns the RX bytes.
module spi_xfer_seq
    import spi_pkg::*;
#(
    parameter int LEN_W     = 8,
    parameter int DLY_W     = 8,
    parameter int CS_SETUP  = 1,
    parameter int CS_HOLD   = 1,
    parameter int INTER_GAP = 0
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             istart,
    input  logic [LEN_W-1:0] ilen,
    input  logic             iabort,
    output logic             obusy,
    output logic             odone,
    output logic [LEN_W-1:0] ocount,
    input  logic             itx_valid,
    input  logic [BYTE-1:0]  itx_data,
    output logic             otx_ready,
    output logic             orx_valid,
    output logic [BYTE-1:0]  orx_data,
    input  logic             irx_ready,
    output logic             ocs_n,
    output logic             oexch,
    output logic [BYTE-1:0]  oexch_data,
    input  logic             iexch_busy,
    input  logic             iexch_ready,
    input  logic [BYTE-1:0]  iexch_data
);

    localparam logic [DLY_W-1:0] SETUP_LD = DLY_W'(CS_SETUP);
    localparam logic [DLY_W-1:0] HOLD_LD  = DLY_W'(CS_HOLD);
    localparam logic [DLY_W-1:0] GAP_LD   = DLY_W'(INTER_GAP);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len;
    logic             abort_pending;
    logic             dly_load;
    logic [DLY_W-1:0] dly_val;
    logic [DLY_W-1:0] dly_value;
    logic             dly_zero;
    logic             last_byte;

    spi_delay_cnt #(.DLY_W(DLY_W)) u_dly (
        .iclk      (iclk),
        .irst_n    (irst_n),
        .iload     (dly_load),
        .iload_val (dly_val),
        .idec      (is_timed(state)),
        .ovalue    (dly_value),
        .ozero     (dly_zero)
    );

    assign last_byte = (ocount == len);
    assign obusy     = (state != ST_IDLE);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        otx_ready = 1'b0;
        oexch     = 1'b0;
        dly_load  = 1'b0;
        dly_val   = '0;
        case (state)
            ST_IDLE: begin
                if (istart && (ilen != '0)) begin
                    state_nxt = ST_SETUP;
                    dly_load  = 1'b1;
                    dly_val   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (dly_zero) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                // A pending abort closes the burst here, before another byte is taken.
                if (abort_pending) begin
                    state_nxt = ST_HOLD;
                    dly_load  = 1'b1;
                    dly_val   = HOLD_LD;
                end else begin
                    otx_ready = 1'b1;
                    if (itx_valid) state_nxt = ST_EXCH;
                end
            end
            ST_EXCH: begin
                if (!iexch_busy) begin
                    oexch     = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (iexch_ready) state_nxt = ST_RXOUT;
            end
            ST_RXOUT: begin
                if (irx_ready) begin
                    dly_load = 1'b1;
                    if (last_byte || abort_pending) begin
                        state_nxt = ST_HOLD;
                        dly_val   = HOLD_LD;
                    end else begin
                        state_nxt = ST_GAP;
                        dly_val   = GAP_LD;
                    end
                end
            end
            ST_GAP: begin
                if (dly_zero) state_nxt = ST_FETCH;
            end
            ST_HOLD: begin
                if (dly_zero) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            ocs_n         <= CS_IDLE;
            odone         <= 1'b0;
            ocount        <= '0;
            orx_valid     <= 1'b0;
            orx_data      <= '0;
            oexch_data    <= '0;
            len           <= '0;
            abort_pending <= 1'b0;
        end else begin
            odone <= 1'b0;
            if ((state != ST_IDLE) && iabort) abort_pending <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (istart) begin
                        ocount <= '0;
                        if (ilen != '0) begin
                            len   <= ilen;
                            ocs_n <= CS_ACTIVE;
                        end else begin
                            odone <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (otx_ready && itx_valid) oexch_data <= itx_data;
                end
                ST_WAIT: begin
                    if (iexch_ready) begin
                        orx_data  <= iexch_data;
                        orx_valid <= 1'b1;
                        ocount    <= ocount + 1'b1;
                    end
                end
                ST_RXOUT: begin
                    if (irx_ready) orx_valid <= 1'b0;
                end
                ST_HOLD: begin
                    // Clearing here overrides a same-cycle iabort: the burst is already over.
                    if (dly_zero) begin
                        ocs_n         <= CS_IDLE;
                        odone         <= 1'b1;
                        abort_pending <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // The zero flag must always agree with the counter value it summarises.
    a_dly_zero_consistent : assert property (
        @(posedge iclk) disable iff (!irst_n) dly_zero == (dly_value == '0)
    );

endmodule
